ball_motion_datapath: RTL and testbench

- Ball-movement datapath stage that sits beside the ball-direction FSM in control_unit.
- Consumes cw_ballMovement (direction command) and steps the ball position once per frame tick.
- Detects paddle, border and goal contacts and returns a one-cycle sw_ballMovement event to the control unit.
- Drives ball_x/ball_y to the VGA renderer and score pulses to the scoreboard.

---
 rtl/ball_if.sv | 24 ++
 rtl/ball_motion_datapath.sv | 177 +++++++++++++++++
 tb/tb_ball_motion_datapath.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_if.sv
// Bundle between the ball-movement datapath and its control/render neighbours:
// direction command and tick in, position, contact event and score pulses out.
interface ball_if;
  logic       move_tick;
  logic [3:0] cw_ballMovement;
  logic [9:0] paddle_left_y;
  logic [9:0] paddle_right_y;
  logic [3:0] sw_ballMovement;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       score_left;
  logic       score_right;
  logic       busy;

  modport master (
    output move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
    input  sw_ballMovement, ball_x, ball_y, score_left, score_right, busy
  );

  modport slave (
    input  move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
    output sw_ballMovement, ball_x, ball_y, score_left, score_right, busy
  );
endinterface

// File: rtl/ball_motion_datapath.sv
// Steps the ball once per frame tick, then classifies the resulting contact
// (goal, paddle, wall) into a one-cycle event code for the control FSM.
module ball_motion_datapath #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int STEP           = 2,
  parameter int BORDER         = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_FRAMES   = 60
) (
  input logic clk,
  input logic reset,
  ball_if.slave bus
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BALL_W = 11'(BALL_SIZE);
  localparam logic [10:0] X_MIN  = 11'd0;
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MIN  = 11'(BORDER);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BORDER - BALL_SIZE);
  localparam logic [10:0] LPX    = 11'(LEFT_PADDLE_X);
  localparam logic [10:0] RPX    = 11'(RIGHT_PADDLE_X);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [9:0]  XC     = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  YC     = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0] SERVE_INIT = CNT_W'(SERVE_FRAMES);

  localparam logic [3:0] CW_UR  = 4'b0100;
  localparam logic [3:0] CW_UL  = 4'b0010;
  localparam logic [3:0] CW_DL  = 4'b0011;
  localparam logic [3:0] CW_DR  = 4'b0001;
  localparam logic [3:0] CW_CTR = 4'b0101;

  localparam logic [3:0] EV_NONE = 4'b0000;
  localparam logic [3:0] EV_RPAD = 4'b0001;
  localparam logic [3:0] EV_LPAD = 4'b0010;
  localparam logic [3:0] EV_TOP  = 4'b0011;
  localparam logic [3:0] EV_BOT  = 4'b0100;
  localparam logic [3:0] EV_GOAL = 4'b0101;

  typedef enum logic [1:0] {IDLE, MOVE, CHECK, SETTLE} state_t;

  state_t state, state_next;

  logic [9:0]       ball_x, ball_y, x_next, y_next;
  logic [CNT_W-1:0] serve_cnt;
  logic [3:0]       sw, ev_code;
  logic             score_left, score_right;
  logic             mv_left, mv_right, mv_up, mv_down, mv_ctr;
  logic             goal_l, goal_r, hit_l, hit_r, hit_top, hit_bot;
  logic [10:0]      x11, y11, pl11, pr11;

  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [10:0] hi);
    logic [10:0] s;
    s = {1'b0, v} + STEP_W;
    return (s > hi) ? hi[9:0] : s[9:0];
  endfunction

  function automatic logic [9:0] sat_dec(input logic [9:0] v, input logic [10:0] lo);
    return ({1'b0, v} < lo + STEP_W) ? lo[9:0] : v - STEP_W[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Ticks arriving outside IDLE are dropped, never queued.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.move_tick) state_next = MOVE;
      MOVE:    state_next = CHECK;
      CHECK:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mv_ctr   = (bus.cw_ballMovement == CW_CTR);
    mv_right = (bus.cw_ballMovement == CW_UR) || (bus.cw_ballMovement == CW_DR);
    mv_left  = (bus.cw_ballMovement == CW_UL) || (bus.cw_ballMovement == CW_DL);
    mv_up    = (bus.cw_ballMovement == CW_UR) || (bus.cw_ballMovement == CW_UL);
    mv_down  = (bus.cw_ballMovement == CW_DL) || (bus.cw_ballMovement == CW_DR);

    x_next = ball_x;
    y_next = ball_y;
    if (mv_ctr) begin
      x_next = XC;
      y_next = YC;
    end else begin
      if (mv_right) x_next = sat_inc(ball_x, X_MAX);
      if (mv_left)  x_next = sat_dec(ball_x, X_MIN);
      if (mv_down)  y_next = sat_inc(ball_y, Y_MAX);
      if (mv_up)    y_next = sat_dec(ball_y, Y_MIN);
    end
  end

  // Contact detection on the freshly stepped position; 11-bit sums cannot wrap.
  always_comb begin
    x11  = {1'b0, ball_x};
    y11  = {1'b0, ball_y};
    pl11 = {1'b0, bus.paddle_left_y};
    pr11 = {1'b0, bus.paddle_right_y};

    goal_l  = mv_left  && (x11 == X_MIN);
    goal_r  = mv_right && (x11 == X_MAX);
    hit_l   = mv_left && (x11 <= LPX + PW) && (x11 + BALL_W > LPX)
              && (y11 + BALL_W > pl11) && (y11 < pl11 + PH);
    hit_r   = mv_right && (x11 + BALL_W >= RPX) && (x11 < RPX + PW)
              && (y11 + BALL_W > pr11) && (y11 < pr11 + PH);
    hit_top = mv_up   && (y11 <= Y_MIN);
    hit_bot = mv_down && (y11 >= Y_MAX);

    ev_code = EV_NONE;
    if (goal_l || goal_r) ev_code = EV_GOAL;
    else if (hit_l)       ev_code = EV_LPAD;
    else if (hit_r)       ev_code = EV_RPAD;
    else if (hit_top)     ev_code = EV_TOP;
    else if (hit_bot)     ev_code = EV_BOT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x      <= XC;
      ball_y      <= YC;
      serve_cnt   <= SERVE_INIT;
      sw          <= EV_NONE;
      score_left  <= 1'b0;
      score_right <= 1'b0;
    end else begin
      unique case (state)
        MOVE: begin
          if (serve_cnt != '0) begin
            serve_cnt <= serve_cnt - 1'b1;
          end else begin
            ball_x <= x_next;
            ball_y <= y_next;
          end
        end
        CHECK: begin
          sw          <= ev_code;
          score_left  <= goal_r;
          score_right <= goal_l;
          if (goal_l || goal_r) begin
            ball_x    <= XC;
            ball_y    <= YC;
            serve_cnt <= SERVE_INIT;
          end
        end
        SETTLE: begin
          sw          <= EV_NONE;
          score_left  <= 1'b0;
          score_right <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ball_x          = ball_x;
  assign bus.ball_y          = ball_y;
  assign bus.sw_ballMovement = sw;
  assign bus.score_left      = score_left;
  assign bus.score_right     = score_right;
  assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_ball_motion_datapath.sv
// Directed bench: walks the ball to each contact scenario with hand-computed
// positions and checks position, event code and score pulse timing.
module tb_ball_motion_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors = 0;

  ball_if bus();

  ball_motion_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Values captured during one tick: N1 = after edge T, N2 = after T+1, ...
  logic       mid_busy;
  logic [9:0] p_x, p_y, e_x, e_y;
  logic [3:0] ev, ev4;
  logic       sl, sr, sl4, busy4;

  task automatic step(input logic [3:0] c);
    @(negedge clk);
    bus.cw_ballMovement = c;
    bus.move_tick = 1'b1;
    @(negedge clk);
    bus.move_tick = 1'b0;
    mid_busy = bus.busy;
    @(negedge clk);
    p_x = bus.ball_x;
    p_y = bus.ball_y;
    @(negedge clk);
    ev  = bus.sw_ballMovement;
    sl  = bus.score_left;
    sr  = bus.score_right;
    e_x = bus.ball_x;
    e_y = bus.ball_y;
    @(negedge clk);
    ev4   = bus.sw_ballMovement;
    sl4   = bus.score_left;
    busy4 = bus.busy;
  endtask

  task automatic run(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) step(c);
  endtask

  task automatic run_pairs(input logic [3:0] a, input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step(a);
      step(b);
    end
  endtask

  task automatic test_reset();
    bus.move_tick = 1'b0;
    bus.cw_ballMovement = 4'b0000;
    bus.paddle_left_y = 10'd0;
    bus.paddle_right_y = 10'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.ball_x, bus.ball_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (316,236)", bus.ball_x, bus.ball_y);
    end
    vectors++;
    if ({bus.sw_ballMovement, bus.score_left, bus.score_right, bus.busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got sw=%b sl=%b sr=%b busy=%b expected 0000 0 0 0",
               bus.sw_ballMovement, bus.score_left, bus.score_right, bus.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_serve_hold();
    run(4'b0010, 60);
    vectors++;
    if ({e_x, e_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL serve_hold: got (%0d,%0d) expected (316,236)", e_x, e_y);
    end
    step(4'b0010);
    vectors++;
    if ({p_x, p_y} !== {10'd314, 10'd234}) begin
      errors++;
      $display("FAIL serve_release: got (%0d,%0d) expected (314,234)", p_x, p_y);
    end
    vectors++;
    if (mid_busy !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL busy_window: got mid=%b end=%b expected 1 0", mid_busy, busy4);
    end
  endtask

  task automatic test_top_wall();
    run(4'b0010, 113);
    run(4'b0100, 5);
    step(4'b0001);
    vectors++;
    if ({p_x, p_y} !== {10'd100, 10'd10}) begin
      errors++;
      $display("FAIL top_setup: got (%0d,%0d) expected (100,10)", p_x, p_y);
    end
    step(4'b0100);
    vectors++;
    if ({p_x, p_y} !== {10'd102, 10'd8}) begin
      errors++;
      $display("FAIL top_pos: got (%0d,%0d) expected (102,8)", p_x, p_y);
    end
    vectors++;
    if (ev !== 4'b0011 || ev4 !== 4'b0000) begin
      errors++;
      $display("FAIL top_event: got %b then %b expected 0011 then 0000", ev, ev4);
    end
  endtask

  task automatic test_left_paddle();
    run(4'b0011, 38);
    run_pairs(4'b0001, 4'b0011, 34);
    vectors++;
    if ({p_x, p_y} !== {10'd26, 10'd220}) begin
      errors++;
      $display("FAIL lpad_setup: got (%0d,%0d) expected (26,220)", p_x, p_y);
    end
    bus.paddle_left_y = 10'd200;
    step(4'b0010);
    vectors++;
    if ({p_x, p_y} !== {10'd24, 10'd218}) begin
      errors++;
      $display("FAIL lpad_pos: got (%0d,%0d) expected (24,218)", p_x, p_y);
    end
    vectors++;
    if (ev !== 4'b0010) begin
      errors++;
      $display("FAIL lpad_hit: got %b expected 0010", ev);
    end
    step(4'b0001);
    bus.paddle_left_y = 10'd300;
    step(4'b0010);
    vectors++;
    if (ev !== 4'b0000) begin
      errors++;
      $display("FAIL lpad_miss: got %b expected 0000", ev);
    end
    bus.paddle_left_y = 10'd0;
  endtask

  task automatic test_right_goal();
    run(4'b0001, 41);
    run_pairs(4'b0100, 4'b0001, 131);
    vectors++;
    if ({p_x, p_y} !== {10'd630, 10'd300}) begin
      errors++;
      $display("FAIL goal_setup: got (%0d,%0d) expected (630,300)", p_x, p_y);
    end
    step(4'b0001);
    vectors++;
    if ({p_x, p_y} !== {10'd632, 10'd302}) begin
      errors++;
      $display("FAIL goal_clamp: got (%0d,%0d) expected (632,302)", p_x, p_y);
    end
    vectors++;
    if ({ev, sl, sr} !== {4'b0101, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL goal_event: got sw=%b sl=%b sr=%b expected 0101 1 0", ev, sl, sr);
    end
    vectors++;
    if ({e_x, e_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL goal_centre: got (%0d,%0d) expected (316,236)", e_x, e_y);
    end
    vectors++;
    if ({ev4, sl4} !== 5'd0) begin
      errors++;
      $display("FAIL goal_pulse: got sw=%b sl=%b expected 0000 0", ev4, sl4);
    end
    run(4'b0001, 60);
    vectors++;
    if ({e_x, e_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL goal_serve_hold: got (%0d,%0d) expected (316,236)", e_x, e_y);
    end
    step(4'b0001);
    vectors++;
    if ({p_x, p_y} !== {10'd318, 10'd238}) begin
      errors++;
      $display("FAIL goal_serve_release: got (%0d,%0d) expected (318,238)", p_x, p_y);
    end
  endtask

  task automatic test_paddle_beats_wall();
    run(4'b0001, 112);
    run_pairs(4'b0100, 4'b0001, 18);
    vectors++;
    if ({p_x, p_y} !== {10'd614, 10'd462}) begin
      errors++;
      $display("FAIL rpad_setup: got (%0d,%0d) expected (614,462)", p_x, p_y);
    end
    bus.paddle_right_y = 10'd440;
    step(4'b0001);
    vectors++;
    if ({p_x, p_y} !== {10'd616, 10'd464}) begin
      errors++;
      $display("FAIL rpad_pos: got (%0d,%0d) expected (616,464)", p_x, p_y);
    end
    vectors++;
    if (ev !== 4'b0001) begin
      errors++;
      $display("FAIL rpad_priority: got %b expected 0001", ev);
    end
    step(4'b0011);
    vectors++;
    if ({p_x, p_y, ev} !== {10'd614, 10'd464, 4'b0100}) begin
      errors++;
      $display("FAIL bottom_wall: got (%0d,%0d) sw=%b expected (614,464) 0100", p_x, p_y, ev);
    end
    bus.paddle_right_y = 10'd0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.cw_ballMovement = 4'b0010;
    bus.move_tick = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b expected 1", bus.busy);
    end
    @(negedge clk);
    bus.move_tick = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if ({bus.ball_x, bus.ball_y, bus.busy} !== {10'd612, 10'd462, 1'b0}) begin
      errors++;
      $display("FAIL b2b_once: got (%0d,%0d) busy=%b expected (612,462) 0",
               bus.ball_x, bus.ball_y, bus.busy);
    end
  endtask

  task automatic test_commands();
    step(4'b0111);
    vectors++;
    if ({p_x, p_y, ev} !== {10'd612, 10'd462, 4'b0000}) begin
      errors++;
      $display("FAIL unknown_cw: got (%0d,%0d) sw=%b expected (612,462) 0000", p_x, p_y, ev);
    end
    step(4'b0101);
    vectors++;
    if ({p_x, p_y, ev} !== {10'd316, 10'd236, 4'b0000}) begin
      errors++;
      $display("FAIL centre_cw: got (%0d,%0d) sw=%b expected (316,236) 0000", p_x, p_y, ev);
    end
  endtask

  task automatic test_reset_in_check();
    @(negedge clk);
    bus.cw_ballMovement = 4'b0100;
    bus.move_tick = 1'b1;
    @(negedge clk);
    bus.move_tick = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.ball_x, bus.ball_y} !== {10'd318, 10'd234}) begin
      errors++;
      $display("FAIL rchk_moved: got (%0d,%0d) expected (318,234)", bus.ball_x, bus.ball_y);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({bus.ball_x, bus.ball_y, bus.sw_ballMovement, bus.busy} !== {10'd316, 10'd236, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL rchk_state: got (%0d,%0d) sw=%b busy=%b expected (316,236) 0000 0",
               bus.ball_x, bus.ball_y, bus.sw_ballMovement, bus.busy);
    end
    step(4'b0100);
    vectors++;
    if ({p_x, p_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL rchk_serve: got (%0d,%0d) expected (316,236)", p_x, p_y);
    end
  endtask

  initial begin
    test_reset();
    test_serve_hold();
    test_top_wall();
    test_left_paddle();
    test_right_goal();
    test_paddle_beats_wall();
    test_back_to_back();
    test_commands();
    test_reset_in_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
